// File: rtl/jesd204b_rx_octet_aligner_if.sv
// Octet-aligner bus: raw PHY word in, rotated word plus lock status out.
interface jesd204b_rx_octet_aligner_if;
  logic [31:0] phy_data;
  logic [3:0]  phy_datak;
  logic        align_en;
  logic [31:0] rx_parallel_data;
  logic [3:0]  rx_datak;
  logic        aligned;
  logic [1:0]  octet_offset;
  logic [7:0]  realign_cnt;

  modport master (
    output phy_data, phy_datak, align_en,
    input  rx_parallel_data, rx_datak, aligned, octet_offset, realign_cnt
  );

  modport slave (
    input  phy_data, phy_datak, align_en,
    output rx_parallel_data, rx_datak, aligned, octet_offset, realign_cnt
  );
endinterface

// File: rtl/jesd204b_rx_octet_aligner.sv
// Rotates the 4-octet PHY word so ILAS /R/ lands in octet 0 and /A/ in octet 3,
// locking the rotation during ILAS and dropping lock on misalignment or CGS re-entry.
module jesd204b_rx_octet_aligner #(
  parameter int CHECK_CNT    = 4,
  parameter int MISALIGN_MAX = 3
) (
  input  logic                       clk,
  input  logic                       reset_b,
  jesd204b_rx_octet_aligner_if.slave bus
);

  localparam logic [7:0] K_R      = 8'h1C;
  localparam logic [7:0] K_A      = 8'h7C;
  localparam logic [3:0] LP_CHECK = 4'(CHECK_CNT);
  localparam logic [3:0] LP_MISS  = 4'(MISALIGN_MAX);

  typedef enum logic [1:0] {ST_HUNT, ST_CHECK, ST_LOCKED} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_off, w_off_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_miss, w_miss_nxt;
  logic [7:0]  r_realign, w_realign_nxt, w_realign_inc;
  logic        r_align_d, w_rise;

  logic [31:0] r_prev_p0;
  logic [3:0]  r_prevk_p0;
  logic [63:0] w_cat;
  logic [7:0]  w_catk;
  logic [31:0] r_data_p1;
  logic [3:0]  r_datak_p1;

  logic        w_r_found, w_a_found, w_r_ok, w_a_ok, w_bad;
  logic [1:0]  w_rpos, w_apos;

  // Stage p0: previous raw word, concatenated with the current one for rotation
  assign w_cat  = {bus.phy_data, r_prev_p0};
  assign w_catk = {bus.phy_datak, r_prevk_p0};

  // Stage p1: rotated output word; always uses the offset currently in force
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_prev_p0  <= '0;
      r_prevk_p0 <= '0;
      r_data_p1  <= '0;
      r_datak_p1 <= '0;
    end else begin
      r_prev_p0  <= bus.phy_data;
      r_prevk_p0 <= bus.phy_datak;
      r_data_p1  <= w_cat[{1'b0, r_off, 3'b000} +: 32];
      r_datak_p1 <= w_catk[{1'b0, r_off} +: 4];
    end
  end

  // Downward scan so the lowest matching octet index wins
  always_comb begin
    w_r_found = 1'b0;
    w_rpos    = 2'd0;
    w_a_found = 1'b0;
    w_apos    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.phy_datak[i] && (bus.phy_data[8*i +: 8] == K_R)) begin
        w_r_found = 1'b1;
        w_rpos    = 2'(i);
      end
      if (bus.phy_datak[i] && (bus.phy_data[8*i +: 8] == K_A)) begin
        w_a_found = 1'b1;
        w_apos    = 2'(i);
      end
    end
  end

  // /A/ belongs one octet before the /R/ position, modulo 4
  assign w_r_ok        = (w_rpos == r_off);
  assign w_a_ok        = (w_apos == (r_off - 2'd1));
  assign w_bad         = (w_r_found && !w_r_ok) || (w_a_found && !w_a_ok);
  assign w_rise        = bus.align_en && !r_align_d;
  assign w_realign_inc = (r_realign == 8'hFF) ? r_realign : (r_realign + 8'd1);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= ST_HUNT;
      r_off     <= 2'd0;
      r_cnt     <= 4'd0;
      r_miss    <= 4'd0;
      r_realign <= 8'd0;
      r_align_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_off     <= w_off_nxt;
      r_cnt     <= w_cnt_nxt;
      r_miss    <= w_miss_nxt;
      r_realign <= w_realign_nxt;
      r_align_d <= bus.align_en;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_off_nxt     = r_off;
    w_cnt_nxt     = r_cnt;
    w_miss_nxt    = r_miss;
    w_realign_nxt = r_realign;
    case (r_state)
      ST_HUNT: begin
        if (w_r_found) begin
          w_off_nxt   = w_rpos;
          w_cnt_nxt   = 4'd1;
          w_miss_nxt  = 4'd0;
          w_state_nxt = (LP_CHECK == 4'd1) ? ST_LOCKED : ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_rise) begin
          w_state_nxt = ST_HUNT;
        end else if (w_r_found && !w_r_ok) begin
          // Drop through HUNT and re-seed at the new offset in one cycle
          w_off_nxt = w_rpos;
          w_cnt_nxt = 4'd1;
        end else if (w_a_found && !w_a_ok) begin
          w_state_nxt = ST_HUNT;
        end else if (w_r_found) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if ((r_cnt + 4'd1) == LP_CHECK) begin
            w_state_nxt = ST_LOCKED;
            w_miss_nxt  = 4'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (w_rise) begin
          w_state_nxt   = ST_HUNT;
          w_realign_nxt = w_realign_inc;
        end else if (w_r_found || w_a_found) begin
          if (!w_bad) begin
            w_miss_nxt = 4'd0;
          end else if ((r_miss + 4'd1) == LP_MISS) begin
            w_state_nxt   = ST_HUNT;
            w_miss_nxt    = 4'd0;
            w_realign_nxt = w_realign_inc;
          end else begin
            w_miss_nxt = r_miss + 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  assign bus.rx_parallel_data = r_data_p1;
  assign bus.rx_datak         = r_datak_p1;
  assign bus.aligned          = (r_state == ST_LOCKED);
  assign bus.octet_offset     = r_off;
  assign bus.realign_cnt      = r_realign;

endmodule

// File: tb/tb_jesd204b_rx_octet_aligner.sv
// Scoreboard bench for the octet aligner: rotated ILAS streams, relock, misalignment, CGS re-entry, reset.
module tb_jesd204b_rx_octet_aligner;

  logic clk     = 1'b0;
  logic reset_b = 1'b1;
  always #5 clk = ~clk;

  jesd204b_rx_octet_aligner_if bus();

  jesd204b_rx_octet_aligner #(.CHECK_CNT(4), .MISALIGN_MAX(3)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
  } exp_t;

  localparam logic [31:0] R_WORD = 32'h661C7788;  // /R/ in raw octet 2

  exp_t        sb_q[$];
  logic [7:0]  oq_d[$];
  logic        oq_k[$];
  logic [31:0] tb_prev;
  logic [3:0]  tb_prevk;
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_re;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Datapath scoreboard: each driven word produces exactly one output one clock later
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_val("rx_data", bus.rx_parallel_data, e.d);
      chk_val("rx_datak", 32'(bus.rx_datak), 32'(e.k));
    end
  end

  task automatic drive_raw(input logic [31:0] d, input logic [3:0] k, input logic ae, input int eo);
    logic [63:0] c;
    logic [7:0]  ck;
    exp_t        e;
    @(negedge clk);
    bus.phy_data  = d;
    bus.phy_datak = k;
    bus.align_en  = ae;
    c   = {d, tb_prev};
    ck  = {k, tb_prevk};
    e.d = 32'(c >> (8 * eo));
    e.k = 4'(ck >> eo);
    sb_q.push_back(e);
    tb_prev  = d;
    tb_prevk = k;
    @(posedge clk);
    #2;
  endtask

  task automatic add_oct(input logic [7:0] d, input logic k);
    oq_d.push_back(d);
    oq_k.push_back(k);
  endtask

  task automatic add_fill(input int n);
    for (int i = 0; i < n; i++) add_oct(8'hBC, 1'b1);
  endtask

  task automatic add_data(input int n);
    for (int i = 0; i < n; i++) add_oct(8'(8'h40 + i), 1'b0);
  endtask

  task automatic add_mf();
    add_oct(8'h1C, 1'b1);
    for (int i = 0; i < 14; i++) add_oct(8'(8'h80 + i), 1'b0);
    add_oct(8'h7C, 1'b1);
  endtask

  task automatic drive_oct(input int eo);
    logic [31:0] d;
    logic [3:0]  k;
    for (int i = 0; i < 4; i++) begin
      d[8*i +: 8] = oq_d.pop_front();
      k[i]        = oq_k.pop_front();
    end
    drive_raw(d, k, 1'b0, eo);
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    #1;
    chk_val("rst_data", bus.rx_parallel_data, 32'h0);
    chk_val("rst_datak", 32'(bus.rx_datak), 32'h0);
    chk_val("rst_aligned", 32'(bus.aligned), 32'h0);
    chk_val("rst_offset", 32'(bus.octet_offset), 32'h0);
    chk_val("rst_realign", 32'(bus.realign_cnt), 32'h0);
    sb_q.delete();
    tb_prev       = '0;
    tb_prevk      = '0;
    bus.phy_data  = '0;
    bus.phy_datak = '0;
    bus.align_en  = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
  endtask

  // Stream delayed by two octets: locks at offset 2 on the fourth /R/
  task automatic scen_rot2();
    add_fill(2);
    for (int i = 0; i < 4; i++) add_mf();
    add_data(14);
    for (int w = 0; w < 20; w++) begin
      drive_oct((w == 0) ? 0 : 2);
      if (w == 11) chk_val("rot2_not_yet", 32'(bus.aligned), 32'h0);
      if (w == 12) begin
        chk_val("rot2_aligned", 32'(bus.aligned), 32'h1);
        chk_val("rot2_offset", 32'(bus.octet_offset), 32'h2);
      end
      if (w == 13) begin
        chk_val("rot2_r_oct0", 32'(bus.rx_parallel_data[7:0]), 32'h1C);
        chk_val("rot2_r_k0", 32'(bus.rx_datak[0]), 32'h1);
      end
      if (w == 16) begin
        chk_val("rot2_a_oct3", 32'(bus.rx_parallel_data[31:24]), 32'h7C);
        chk_val("rot2_a_k3", 32'(bus.rx_datak[3]), 32'h1);
      end
    end
  endtask

  initial begin
    bus.phy_data  = '0;
    bus.phy_datak = '0;
    bus.align_en  = 1'b0;
    tb_prev       = '0;
    tb_prevk      = '0;
    #2;

    // Offset-0 stream: output is the input delayed by one clock
    do_reset();
    for (int i = 0; i < 4; i++) add_mf();
    add_data(8);
    for (int w = 0; w < 18; w++) begin
      drive_oct(0);
      if (w == 11) chk_val("off0_not_yet", 32'(bus.aligned), 32'h0);
      if (w == 12) begin
        chk_val("off0_aligned", 32'(bus.aligned), 32'h1);
        chk_val("off0_offset", 32'(bus.octet_offset), 32'h0);
      end
    end

    // Second /R/ slips to octet 1 while checking: re-seed at offset 1 with count 1
    do_reset();
    add_fill(2);
    add_mf();
    add_fill(3);
    for (int i = 0; i < 4; i++) add_mf();
    add_data(11);
    for (int w = 0; w < 24; w++) begin
      drive_oct((w == 0) ? 0 : ((w <= 5) ? 2 : 1));
      if (w == 0) chk_val("slip_seed_off", 32'(bus.octet_offset), 32'h2);
      if (w == 5) begin
        chk_val("slip_reseed_off", 32'(bus.octet_offset), 32'h1);
        chk_val("slip_not_aligned", 32'(bus.aligned), 32'h0);
      end
      if (w == 13) chk_val("slip_cnt3", 32'(bus.aligned), 32'h0);
      if (w == 17) begin
        chk_val("slip_locked", 32'(bus.aligned), 32'h1);
        chk_val("slip_lock_off", 32'(bus.octet_offset), 32'h1);
      end
    end

    do_reset();
    scen_rot2();

    // Locked at offset 2: /A/ belongs in raw octet 1; two misses then a hit keep lock
    drive_raw(32'h3344557C, 4'b0001, 1'b0, 2);
    chk_val("miss1_locked", 32'(bus.aligned), 32'h1);
    drive_raw(32'h3344557C, 4'b0001, 1'b0, 2);
    chk_val("miss2_locked", 32'(bus.aligned), 32'h1);
    drive_raw(32'h33447C55, 4'b0010, 1'b0, 2);
    chk_val("good_locked", 32'(bus.aligned), 32'h1);
    drive_raw(32'h3344557C, 4'b0001, 1'b0, 2);
    drive_raw(32'h3344557C, 4'b0001, 1'b0, 2);
    chk_val("miss_after_clear", 32'(bus.aligned), 32'h1);
    chk_val("realign_before", 32'(bus.realign_cnt), 32'h0);
    drive_raw(32'h3344557C, 4'b0001, 1'b0, 2);
    chk_val("miss3_unlocked", 32'(bus.aligned), 32'h0);
    chk_val("realign_after_miss", 32'(bus.realign_cnt), 32'h1);

    // CGS re-entry pulses: each drops lock and bumps the saturating realign count
    exp_re = 1;
    for (int i = 0; i < 300; i++) begin
      repeat (4) drive_raw(R_WORD, 4'b0100, 1'b0, 2);
      chk_val("cgs_relock", 32'(bus.aligned), 32'h1);
      drive_raw(32'h0, 4'b0000, 1'b1, 2);
      exp_re = (exp_re >= 255) ? 255 : exp_re + 1;
      chk_val("cgs_unlock", 32'(bus.aligned), 32'h0);
      chk_val("cgs_realign", 32'(bus.realign_cnt), 32'(exp_re));
    end
    chk_val("realign_sat", 32'(bus.realign_cnt), 32'd255);

    // Asynchronous reset in the middle of LOCKED, then relock from scratch
    repeat (4) drive_raw(R_WORD, 4'b0100, 1'b0, 2);
    chk_val("pre_reset_locked", 32'(bus.aligned), 32'h1);
    @(posedge clk);
    #3;
    do_reset();
    scen_rot2();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
